onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
- Collects up to 8 independent request lines into a pending register.
- Selects one pending request per transaction with a round-robin arbiter.
- Presents the selection as a registered one-hot grant word with a valid/ready handshake.
- Sits directly upstream of the 8x3 one-hot encoder: `grant` drives the encoder's 8-bit data input. The block also provides its own binary `code` for cross-checking against the encoder.

Parameters:
- None. Fixed width of 8 requests and 3-bit code, matching the downstream encoder.

Ports:
- `clk`  input  1  Single system clock; all state updates on rising edge.
- `rst`  input  1  Synchronous, active-high reset.
- `req`  input  8  Request lines, sampled every edge; any high bit marks that source pending.
- `ready`  input  1  Consumer accepts the current grant when `valid` && `ready` at an edge.
- `clr_ovf`  input  1  Synchronous clear of the `ovf` sticky flag.
- `grant`  output  8  Registered one-hot grant; all zeros when `valid`=0.
- `code`  output  3  Registered binary index of the set `grant` bit; 0 when `valid`=0.
- `valid`  output  1  `grant`/`code` hold a live transaction.
- `pending`  output  8  Current pending register, for debug.
- `ovf`  output  1  Sticky: a request arrived for a source already pending.

Behaviour:
- Reset, applied at the edge while `rst`=1, sets:
  - `pending`=0, `grant`=0, `code`=0, `valid`=0, `ovf`=0.
  - Round-robin pointer `ptr`=7, so the first search starts at bit 0.
- Reset overrides all other inputs. Reset mid-transaction drops the held grant and all pending requests with no acceptance.
- Accept event: `acc` = `valid` && `ready`.
- Pending update each edge: `pending_next` = (`pending` & ~(`acc` ? `grant` : 0)) | `req`.
  - Set wins: a `req` bit equal to the bit being accepted in the same cycle stays pending.
- Overflow: `ovf` sets at an edge if any bit has `req`[i]=1 && `pending`[i]=1 && !(`acc` && `grant`[i]).
  - The request is not lost; the pending bit simply stays 1.
  - `clr_ovf` clears `ovf`. If set and clear occur in the same cycle, set wins.
- Arbitration candidate set: `cand` = `pending` & ~(`acc` ? `grant` : 0).
  - Uses the registered `pending` value, so requests arriving this cycle are excluded.
- Output register load condition: !`valid` || `acc`.
  - If `cand`≠0: `grant` = one-hot of the first set bit of `cand`, searching `ptr`+1, `ptr`+2, …, `ptr`+8 modulo 8. `code` = that index, `valid`=1, `ptr` = that index.
  - If `cand`=0: `valid`=0, `grant`=0, `code`=0, `ptr` unchanged.
- When `valid`=1 && `ready`=0, `grant`, `code`, `valid` and `ptr` hold stable.
  - The presented bit stays in `pending` and is not re-selected.
- Latency: `req`[i] high in cycle N with the block idle → `pending`[i]=1 after edge N → `valid`=1 and `grant`[i]=1 after edge N+1.
- Throughput: one grant per cycle with `ready` held high, back-to-back with no bubble.
- Invariants:
  - `grant` is always one-hot or zero.
  - `code` always equals the encoder's function of `grant`.
  - `grant` is a subset of `pending` whenever `valid`=1.

Test Plan:
- Reset/idle: assert `rst` for 2 cycles with `req`=8'hFF → `pending`=0, `valid`=0, `grant`=0, `code`=0, `ovf`=0. After release with `req`=0, outputs stay zero.
- Single request latency: `req`=8'b0000_0100 for one cycle, `ready`=1 → next edge `pending`=8'h04. Following edge `grant`=8'h04, `code`=3'b010, `valid`=1. Next edge `valid`=0, `pending`=0.
- Round-robin fairness: `req`=8'b1000_1001 pulsed once, `ready`=1 → grants in consecutive cycles are 8'h01 (`code` 0), 8'h08 (`code` 3), 8'h80 (`code` 7), then `valid`=0. Re-pulse 8'h81 → 8'h01 then 8'h80.
- Backpressure: `pending`=8'h22, `ready`=0 for 5 cycles → `grant`=8'h02, `code`=1 held stable for all 5 cycles. Raise `ready` → 8'h20 (`code` 5) on the next cycle.
- Overflow and set-wins:
  - With `pending`[3]=1 and not accepting, pulse `req`[3] → `ovf`=1, `pending` unchanged. Pulse `clr_ovf` → `ovf`=0.
  - Pulse `req`[3] in the same cycle `grant`=8'h08 is accepted → `pending`[3] remains 1, `ovf` stays 0, bit 3 re-granted later.
- Reset mid-operation: `pending`=8'hF0, `valid`=1, `ready`=0; assert `rst` one cycle → all outputs 0. `req`=8'h10 afterwards yields `grant`=8'h10, `code`=4 (pointer restarted at 0).

Source files
------------

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between the request sources, the round-robin arbiter
// and the downstream consumer/encoder.
interface onehot_rr_arbiter_if;
    logic [7:0] req;
    logic       ready;
    logic [7:0] grant;
    logic [2:0] code;
    logic       valid;

    modport master (
        input  req,
        input  ready,
        output grant,
        output code,
        output valid
    );

    modport slave (
        output req,
        output ready,
        input  grant,
        input  code,
        input  valid
    );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Eight-source round-robin arbiter: collects requests into a pending register
// and presents one registered one-hot grant at a time over valid/ready.
module onehot_rr_arbiter (
    input  logic                       clk,
    input  logic                       rst,
    onehot_rr_arbiter_if.master        bus,
    input  logic                       clr_ovf,
    output logic [7:0]                 pending,
    output logic                       ovf
);

    logic [7:0] pending_q, pending_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [2:0] ptr_q, ptr_d;
    logic       ovf_q, ovf_d;

    logic       acc;
    logic       load;
    logic [7:0] acc_mask;
    logic [7:0] cand;
    logic       found;
    logic [2:0] sel;
    logic [2:0] idx;

    always_comb begin
        acc      = valid_q && bus.ready;
        acc_mask = acc ? grant_q : 8'h00;
        cand     = pending_q & ~acc_mask;
        load     = !valid_q || acc;

        // Set wins over both the acceptance clear and the overflow clear.
        pending_d = cand | bus.req;
        ovf_d     = (|(bus.req & cand)) | (ovf_q & ~clr_ovf);

        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        grant_d = grant_q;
        code_d  = code_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (found) begin
                grant_d = 8'b1 << sel;
                code_d  = sel;
                valid_d = 1'b1;
                ptr_d   = sel;
            end else begin
                grant_d = '0;
                code_d  = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            grant_q   <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= 3'd7;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            grant_q   <= grant_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: directed scenarios plus a
// randomized run against a per-source behavioural model.
module tb_onehot_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       clr_ovf;
    logic [7:0] pending;
    logic       ovf;

    onehot_rr_arbiter_if bus();

    onehot_rr_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .clr_ovf (clr_ovf),
        .pending (pending),
        .ovf     (ovf)
    );

    int tests_run = 0;
    int fails     = 0;

    // Behavioural model: per-source pending flags, index of presented source.
    bit m_pend [8];
    bit m_valid;
    int m_gidx;
    int m_ptr;
    bit m_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_pending();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [7:0] model_grant();
        return m_valid ? (8'b1 << m_gidx) : 8'h00;
    endfunction

    function automatic logic [2:0] model_code();
        return m_valid ? 3'(m_gidx) : 3'd0;
    endfunction

    // Advance model and DUT by one edge using the currently driven inputs.
    task automatic cycle();
        bit n_pend [8];
        bit stays  [8];
        bit n_valid;
        int n_gidx;
        int n_ptr;
        bit n_ovf;
        bit accept;
        bit oset;
        if (rst) begin
            for (int i = 0; i < 8; i++) n_pend[i] = 1'b0;
            n_valid = 1'b0;
            n_gidx  = 0;
            n_ptr   = 7;
            n_ovf   = 1'b0;
        end else begin
            accept = m_valid && bus.ready;
            oset   = 1'b0;
            for (int i = 0; i < 8; i++) begin
                stays[i]  = m_pend[i] && !(accept && m_gidx == i);
                n_pend[i] = stays[i] || bus.req[i];
                if (bus.req[i] && stays[i]) oset = 1'b1;
            end
            n_ovf   = oset || (m_ovf && !clr_ovf);
            n_valid = m_valid;
            n_gidx  = m_gidx;
            n_ptr   = m_ptr;
            if (!m_valid || accept) begin
                n_valid = 1'b0;
                for (int k = 1; k <= 8; k++) begin
                    if (!n_valid && stays[(m_ptr + k) % 8]) begin
                        n_valid = 1'b1;
                        n_gidx  = (m_ptr + k) % 8;
                        n_ptr   = n_gidx;
                    end
                end
                if (!n_valid) n_gidx = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) m_pend[i] = n_pend[i];
        m_valid = n_valid;
        m_gidx  = n_gidx;
        m_ptr   = n_ptr;
        m_ovf   = n_ovf;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 8'h00;
        bus.ready = 1'b0;
        clr_ovf = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 8'hFF;
        bus.ready = 1'b1;
        clr_ovf = 1'b0;
        cycle();
        cycle();
        tests_run++;
        if ({pending, bus.grant, bus.code, bus.valid, ovf} !== 21'd0) begin
            fails++;
            $display("FAIL reset_state: pending=%h grant=%h code=%0d valid=%b ovf=%b, required all zero",
                     pending, bus.grant, bus.code, bus.valid, ovf);
        end
        rst = 1'b0;
        bus.req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests_run++;
            if ({pending, bus.grant, bus.code, bus.valid, ovf} !== 21'd0) begin
                fails++;
                $display("FAIL idle_after_reset: pending=%h grant=%h code=%0d valid=%b ovf=%b, required all zero",
                         pending, bus.grant, bus.code, bus.valid, ovf);
            end
        end
    endtask

    task automatic test_single_latency();
        do_reset();
        bus.ready = 1'b1;
        bus.req = 8'h04;
        cycle();
        tests_run++;
        if (pending !== 8'h04 || bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL single_pending: pending=%h valid=%b, required pending=04 valid=0", pending, bus.valid);
        end
        bus.req = 8'h00;
        cycle();
        tests_run++;
        if (bus.grant !== 8'h04 || bus.code !== 3'd2 || bus.valid !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: grant=%h code=%0d valid=%b, required 04/2/1", bus.grant, bus.code, bus.valid);
        end
        cycle();
        tests_run++;
        if (bus.valid !== 1'b0 || pending !== 8'h00 || bus.grant !== 8'h00) begin
            fails++;
            $display("FAIL single_done: valid=%b pending=%h grant=%h, required 0/00/00", bus.valid, pending, bus.grant);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g [5];
        logic [2:0] exp_c [5];
        exp_g = '{8'h01, 8'h08, 8'h80, 8'h01, 8'h80};
        exp_c = '{3'd0, 3'd3, 3'd7, 3'd0, 3'd7};
        do_reset();
        bus.ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            bus.req = (p == 0) ? 8'h89 : 8'h81;
            cycle();
            bus.req = 8'h00;
            for (int g = 0; g < 3 - p; g++) begin
                int j;
                j = (p == 0) ? g : 3 + g;
                cycle();
                tests_run++;
                if (bus.grant !== exp_g[j] || bus.code !== exp_c[j] || bus.valid !== 1'b1) begin
                    fails++;
                    $display("FAIL rr_grant[%0d]: grant=%h code=%0d valid=%b, required %h/%0d/1",
                             j, bus.grant, bus.code, bus.valid, exp_g[j], exp_c[j]);
                end
            end
            cycle();
            tests_run++;
            if (bus.valid !== 1'b0 || bus.grant !== 8'h00) begin
                fails++;
                $display("FAIL rr_idle[%0d]: valid=%b grant=%h, required 0/00", p, bus.valid, bus.grant);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.ready = 1'b0;
        bus.req = 8'h22;
        cycle();
        bus.req = 8'h00;
        for (int c = 0; c < 5; c++) begin
            cycle();
            tests_run++;
            if (bus.grant !== 8'h02 || bus.code !== 3'd1 || bus.valid !== 1'b1 || pending !== 8'h22) begin
                fails++;
                $display("FAIL bp_hold[%0d]: grant=%h code=%0d valid=%b pending=%h, required 02/1/1/22",
                         c, bus.grant, bus.code, bus.valid, pending);
            end
        end
        bus.ready = 1'b1;
        cycle();
        tests_run++;
        if (bus.grant !== 8'h20 || bus.code !== 3'd5 || bus.valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: grant=%h code=%0d valid=%b, required 20/5/1", bus.grant, bus.code, bus.valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.ready = 1'b0;
        bus.req = 8'h08;
        cycle();
        bus.req = 8'h00;
        cycle();
        tests_run++;
        if (ovf !== 1'b0 || bus.grant !== 8'h08) begin
            fails++;
            $display("FAIL ovf_pre: ovf=%b grant=%h, required 0/08", ovf, bus.grant);
        end
        bus.req = 8'h08;
        cycle();
        tests_run++;
        if (ovf !== 1'b1 || pending !== 8'h08) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b pending=%h, required 1/08", ovf, pending);
        end
        bus.req = 8'h00;
        clr_ovf = 1'b1;
        cycle();
        tests_run++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf);
        end
        bus.req = 8'h08;
        cycle();
        tests_run++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set_beats_clear: ovf=%b, required 1", ovf);
        end
        bus.req = 8'h00;
        cycle();
        clr_ovf = 1'b0;
        bus.ready = 1'b1;
        bus.req = 8'h08;
        cycle();
        tests_run++;
        if (pending !== 8'h08 || ovf !== 1'b0 || bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL set_wins: pending=%h ovf=%b valid=%b, required 08/0/0", pending, ovf, bus.valid);
        end
        bus.req = 8'h00;
        cycle();
        tests_run++;
        if (bus.grant !== 8'h08 || bus.code !== 3'd3 || bus.valid !== 1'b1) begin
            fails++;
            $display("FAIL set_wins_regrant: grant=%h code=%0d valid=%b, required 08/3/1", bus.grant, bus.code, bus.valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ready = 1'b0;
        bus.req = 8'hF0;
        cycle();
        bus.req = 8'h00;
        cycle();
        tests_run++;
        if (pending !== 8'hF0 || bus.grant !== 8'h10 || bus.valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: pending=%h grant=%h valid=%b, required F0/10/1", pending, bus.grant, bus.valid);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests_run++;
        if ({pending, bus.grant, bus.code, bus.valid, ovf} !== 21'd0) begin
            fails++;
            $display("FAIL mid_reset: pending=%h grant=%h code=%0d valid=%b ovf=%b, required all zero",
                     pending, bus.grant, bus.code, bus.valid, ovf);
        end
        // 8'h30 distinguishes a restarted pointer (bit 4 first) from a kept one.
        bus.req = 8'h30;
        cycle();
        bus.req = 8'h00;
        cycle();
        tests_run++;
        if (bus.grant !== 8'h10 || bus.code !== 3'd4) begin
            fails++;
            $display("FAIL mid_restart: grant=%h code=%0d, required 10/4", bus.grant, bus.code);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            bus.ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 9) == 0);
            cycle();
            tests_run++;
            if (pending !== model_pending() || bus.grant !== model_grant() || bus.code !== model_code()
                || bus.valid !== m_valid || ovf !== m_ovf) begin
                fails++;
                $display("FAIL random[%0d]: pending=%h grant=%h code=%0d valid=%b ovf=%b, required %h/%h/%0d/%b/%b",
                         c, pending, bus.grant, bus.code, bus.valid, ovf,
                         model_pending(), model_grant(), model_code(), m_valid, m_ovf);
            end
            if (bus.valid === 1'b1) begin
                tests_run++;
                if ((bus.grant & ~pending) !== 8'h00 || $countones(bus.grant) != 1) begin
                    fails++;
                    $display("FAIL random_invariant[%0d]: grant=%h pending=%h, required one-hot subset",
                             c, bus.grant, pending);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 8'h00;
        bus.ready = 1'b0;
        clr_ovf = 1'b0;
        m_valid = 1'b0;
        m_gidx = 0;
        m_ptr = 7;
        m_ovf = 1'b0;
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
